cfg_seq_chk: RTL and testbench

- Parametrised, synthesizable command sequencer and response checker for config-UART bring-up.
- Host loads a queue of commands with expected responses and masks, then issues start.
- Block drives a cfg_mstr (cmd_data/snd_frm), waits for each response and compares it under mask.
- Counts pass, fail and timeout outcomes per run and records the first failing index, replacing hand-coded bench checking loops.

---
 rtl/cfg_seq_chk.sv | 213 +++++++++++++++++++++
 tb/tb_cfg_seq_chk.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_seq_chk.sv
// Command sequencer and response checker: replays a host-loaded queue of config
// frames through a cfg_mstr and scores each response under a per-entry bit mask.
module cfg_seq_chk #(
    parameter int DEPTH   = 16,
    parameter int CMD_W   = 24,
    parameter int RSP_W   = 16,
    parameter int TO_CYC  = 4096,
    parameter int GAP_CYC = 4,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_vld,
    output logic             ld_rdy,
    input  logic [CMD_W-1:0] ld_cmd,
    input  logic [RSP_W-1:0] ld_exp,
    input  logic [RSP_W-1:0] ld_mask,
    input  logic             start,
    input  logic             abort,
    output logic [CMD_W-1:0] cmd_data,
    output logic             snd_frm,
    input  logic             rsp_rdy,
    input  logic [RSP_W-1:0] resp,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] to_cnt,
    output logic             first_fail_vld,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic             stray_rsp,
    output logic [2:0]       dbg_state
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TO_CYC);
    localparam int GW = $clog2(GAP_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SEND = 3'd1,
        S_WAIT = 3'd2,
        S_GAP  = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    logic [CMD_W-1:0] cmd_mem  [DEPTH];
    logic [RSP_W-1:0] exp_mem  [DEPTH];
    logic [RSP_W-1:0] mask_mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;

    state_t           state_q;
    logic             rsp_rdy_q, snd_frm_q, done_q, ffv_q, stray_q;
    logic [CMD_W-1:0] cmd_data_q;
    logic [CNT_W-1:0] pass_q, fail_q, to_q, ffi_q, idx_q;
    logic [TW-1:0]    timer_q;
    logic [GW-1:0]    gap_q;

    logic             rise, empty, push, pop, timeout, wait_done, match;
    logic [CMD_W-1:0] head_cmd;
    logic [RSP_W-1:0] head_exp, head_mask;

    assign head_cmd  = cmd_mem[rd_ptr_q];
    assign head_exp  = exp_mem[rd_ptr_q];
    assign head_mask = mask_mem[rd_ptr_q];

    assign rise      = rsp_rdy & ~rsp_rdy_q;
    assign empty     = (count_q == '0);
    assign ld_rdy    = (count_q != (AW+1)'(DEPTH));
    assign push      = ld_vld & ld_rdy;
    assign match     = ((resp & head_mask) == (head_exp & head_mask));
    assign timeout   = (timer_q == TW'(TO_CYC - 1));
    assign wait_done = rise | timeout;
    assign pop       = (state_q == S_WAIT) & wait_done & ~abort;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + 1'b1;
        else if (pop && !push)
            count_d = count_q - 1'b1;
    end

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            cmd_mem[wr_ptr_q]  <= ld_cmd;
            exp_mem[wr_ptr_q]  <= ld_exp;
            mask_mem[wr_ptr_q] <= ld_mask;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (abort) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rsp_rdy_q  <= 1'b0;
            snd_frm_q  <= 1'b0;
            done_q     <= 1'b0;
            cmd_data_q <= '0;
            pass_q     <= '0;
            fail_q     <= '0;
            to_q       <= '0;
            ffv_q      <= 1'b0;
            ffi_q      <= '0;
            idx_q      <= '0;
            stray_q    <= 1'b0;
            timer_q    <= '0;
            gap_q      <= '0;
        end else begin
            rsp_rdy_q <= rsp_rdy;
            snd_frm_q <= 1'b0;
            done_q    <= 1'b0;
            if (rise && (state_q == S_IDLE || state_q == S_SEND || state_q == S_GAP))
                stray_q <= 1'b1;
            // abort overrides every same-cycle transition and score update.
            if (abort) begin
                state_q <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            pass_q  <= '0;
                            fail_q  <= '0;
                            to_q    <= '0;
                            ffv_q   <= 1'b0;
                            ffi_q   <= '0;
                            idx_q   <= '0;
                            stray_q <= 1'b0;
                            if (!empty) begin
                                state_q    <= S_SEND;
                                cmd_data_q <= head_cmd;
                                snd_frm_q  <= 1'b1;
                            end else begin
                                state_q <= S_FIN;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                    S_SEND: begin
                        timer_q <= '0;
                        state_q <= S_WAIT;
                    end
                    S_WAIT: begin
                        timer_q <= timer_q + 1'b1;
                        if (rise && match) begin
                            pass_q <= sat_inc(pass_q);
                        end else if (wait_done) begin
                            fail_q <= sat_inc(fail_q);
                            if (!rise) to_q <= sat_inc(to_q);
                            if (!ffv_q) begin
                                ffv_q <= 1'b1;
                                ffi_q <= idx_q;
                            end
                        end
                        if (wait_done) begin
                            idx_q   <= idx_q + 1'b1;
                            gap_q   <= '0;
                            state_q <= S_GAP;
                        end
                    end
                    S_GAP: begin
                        if (gap_q == GW'(GAP_CYC - 1)) begin
                            if (!empty) begin
                                state_q    <= S_SEND;
                                cmd_data_q <= head_cmd;
                                snd_frm_q  <= 1'b1;
                            end else begin
                                state_q <= S_FIN;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            gap_q <= gap_q + 1'b1;
                        end
                    end
                    S_FIN:   state_q <= S_IDLE;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign cmd_data       = cmd_data_q;
    assign snd_frm        = snd_frm_q & ~abort;
    assign busy           = (state_q != S_IDLE);
    assign done           = done_q;
    assign pass_cnt       = pass_q;
    assign fail_cnt       = fail_q;
    assign to_cnt         = to_q;
    assign first_fail_vld = ffv_q;
    assign first_fail_idx = ffi_q;
    assign stray_rsp      = stray_q;
    assign dbg_state      = state_q;
endmodule

// File: tb/tb_cfg_seq_chk.sv
// Bench for cfg_seq_chk: scripted responder, per-run outcome model and a
// scoreboard monitor that checks every send strobe and every done pulse.
module tb_cfg_seq_chk;
    localparam int DEPTH = 16;
    localparam int TO    = 16;

    localparam int M_RESP   = 0;  // pulse rsp_rdy with a value after dly cycles
    localparam int M_HOLD   = 1;  // raise rsp_rdy and leave it high
    localparam int M_SILENT = 2;  // never answer
    localparam int M_SSTRAY = 3;  // never answer, then pulse rsp_rdy in the gap
    localparam int M_ABORT  = 4;  // assert abort mid-wait

    typedef struct {
        int          mode;
        logic [15:0] rsp;
        int          dly;
    } plan_t;

    typedef struct {
        logic [31:0] ps;
        logic [31:0] fl;
        logic [31:0] to;
        logic [31:0] ffv;
        logic [31:0] ffi;
        logic [31:0] stray;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_vld, ld_rdy, start, abort, snd_frm, rsp_rdy, busy, done;
    logic [23:0] ld_cmd, cmd_data;
    logic [15:0] ld_exp, ld_mask, resp;
    logic [7:0]  pass_cnt, fail_cnt, to_cnt, first_fail_idx;
    logic        first_fail_vld, stray_rsp;
    logic [2:0]  dbg_state;

    logic [23:0] exp_q[$];
    plan_t       plan_q[$];
    res_t        res_q[$];
    logic [15:0] run_exp[$], run_mask[$], run_rsp[$];
    int          run_mode[$];
    int          model_cnt = 0;
    int          tests_run = 0;
    int          tests_failed = 0;

    cfg_seq_chk #(.DEPTH(DEPTH), .CMD_W(24), .RSP_W(16), .TO_CYC(TO), .GAP_CYC(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .ld_vld(ld_vld), .ld_rdy(ld_rdy), .ld_cmd(ld_cmd),
        .ld_exp(ld_exp), .ld_mask(ld_mask), .start(start), .abort(abort),
        .cmd_data(cmd_data), .snd_frm(snd_frm), .rsp_rdy(rsp_rdy), .resp(resp),
        .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
        .to_cnt(to_cnt), .first_fail_vld(first_fail_vld),
        .first_fail_idx(first_fail_idx), .stray_rsp(stray_rsp), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic load(input logic [23:0] cmd, input logic [15:0] e, input logic [15:0] m,
                        input int mode, input logic [15:0] r, input int dly);
        bit acc;
        plan_t p;
        @(negedge clk);
        acc = (model_cnt < DEPTH);
        check("ld_rdy", 32'(ld_rdy), 32'(acc));
        ld_vld = 1'b1; ld_cmd = cmd; ld_exp = e; ld_mask = m;
        @(posedge clk); #1;
        ld_vld = 1'b0;
        if (acc) begin
            model_cnt++;
            p.mode = mode; p.rsp = r; p.dly = dly;
            exp_q.push_back(cmd);
            plan_q.push_back(p);
            run_exp.push_back(e); run_mask.push_back(m);
            run_rsp.push_back(r); run_mode.push_back(mode);
        end
    endtask

    // Outcome of a whole run from the scoring rules, entry by entry.
    task automatic predict();
        res_t r;
        r = '{default: 32'd0};
        for (int i = 0; i < run_mode.size(); i++) begin
            bit bad;
            bad = 1'b0;
            if (run_mode[i] == M_SILENT || run_mode[i] == M_SSTRAY) begin
                if (r.fl < 255) r.fl++;
                if (r.to < 255) r.to++;
                bad = 1'b1;
            end else if ((run_rsp[i] & run_mask[i]) == (run_exp[i] & run_mask[i])) begin
                if (r.ps < 255) r.ps++;
            end else begin
                if (r.fl < 255) r.fl++;
                bad = 1'b1;
            end
            if (bad && r.ffv == 0) begin
                r.ffv = 1;
                r.ffi = 32'(i % 256);
            end
            if (run_mode[i] == M_SSTRAY) r.stray = 1;
        end
        res_q.push_back(r);
        run_exp.delete(); run_mask.delete(); run_rsp.delete(); run_mode.delete();
    endtask

    task automatic kick();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_run(input int budget);
        int n;
        n = 0;
        while ((res_q.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("run_complete", 32'(n < budget), 32'd1);
        model_cnt = 0;
    endtask

    // Responder: plays the cfg_mstr side according to the plan of each entry.
    initial begin
        plan_t p;
        rsp_rdy = 1'b0; resp = '0; abort = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && snd_frm && plan_q.size() != 0) begin
                p = plan_q.pop_front();
                case (p.mode)
                    M_RESP: begin
                        repeat (p.dly) @(posedge clk);
                        #1 resp = p.rsp; rsp_rdy = 1'b1;
                        @(posedge clk);
                        #1 rsp_rdy = 1'b0;
                    end
                    M_HOLD: begin
                        repeat (p.dly) @(posedge clk);
                        #1 resp = p.rsp; rsp_rdy = 1'b1;
                    end
                    M_SSTRAY: begin
                        repeat (TO + 1) @(posedge clk);
                        #1 rsp_rdy = 1'b0;
                        @(posedge clk);
                        #1 rsp_rdy = 1'b1;
                        @(posedge clk);
                        #1 rsp_rdy = 1'b0;
                    end
                    M_ABORT: begin
                        repeat (3) @(posedge clk);
                        #1 abort = 1'b1;
                        @(posedge clk);
                        #1 abort = 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Monitor: every send must match the next queued command, every done the next result.
    initial begin
        res_t r;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (snd_frm) begin
                    if (exp_q.size() == 0) check("unexpected_snd_frm", 32'd1, 32'd0);
                    else check("cmd_data", 32'(cmd_data), 32'(exp_q.pop_front()));
                end
                if (done) begin
                    if (res_q.size() == 0) begin
                        check("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        r = res_q.pop_front();
                        check("pass_cnt", 32'(pass_cnt), r.ps);
                        check("fail_cnt", 32'(fail_cnt), r.fl);
                        check("to_cnt", 32'(to_cnt), r.to);
                        check("first_fail_vld", 32'(first_fail_vld), r.ffv);
                        check("first_fail_idx", 32'(first_fail_idx), r.ffi);
                        check("stray_rsp", 32'(stray_rsp), r.stray);
                        check("busy_in_fin", 32'(busy), 32'd1);
                    end
                end
            end
        end
    end

    initial begin
        int n;
        logic [15:0] e, m, r, nz;
        int b;
        rst = 1'b1; ld_vld = 1'b0; ld_cmd = '0; ld_exp = '0; ld_mask = '0; start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ld_rdy", 32'(ld_rdy), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_snd_frm", 32'(snd_frm), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cmd_data", 32'(cmd_data), 32'd0);
        check("rst_counts", 32'({pass_cnt, fail_cnt, to_cnt, first_fail_idx}), 32'd0);
        check("rst_flags", 32'({first_fail_vld, stray_rsp}), 32'd0);
        rst = 1'b0;

        // Echo responder, three matching entries.
        load(24'h0C1234, 16'h1234, 16'hFFFF, M_RESP, 16'h1234, $urandom_range(1, 10));
        load(24'h0C0A5A, 16'h0A5A, 16'hFFFF, M_RESP, 16'h0A5A, $urandom_range(1, 10));
        load(24'h0C0001, 16'h0001, 16'hFFFF, M_RESP, 16'h0001, $urandom_range(1, 10));
        predict(); kick(); wait_run(1000);
        check("busy_after_run", 32'(busy), 32'd0);

        // Masked bit 14 passes, a checked-bit difference fails at index 1.
        load(24'h0C35A6, 16'h35A6, 16'h3FFF, M_RESP, 16'h75A6, $urandom_range(1, 10));
        load(24'h0D35A6, 16'h35A6, 16'h3FFF, M_RESP, 16'h35A7, $urandom_range(1, 10));
        predict(); kick(); wait_run(1000);

        // Timeout on entry 0, entry 1 still sent.
        load(24'h111111, 16'h1111, 16'hFFFF, M_SILENT, 16'h0000, 1);
        load(24'h222222, 16'h2222, 16'hFFFF, M_RESP, 16'h2222, $urandom_range(1, 10));
        predict(); kick(); wait_run(1000);

        // Fill to full, overflow push dropped, late push during the run accepted.
        for (int i = 0; i < DEPTH; i++)
            load(24'(24'hA00000 + i), 16'(i), 16'hFFFF, M_RESP, 16'(i), $urandom_range(1, 10));
        load(24'hDEAD00, 16'h0BAD, 16'hFFFF, M_RESP, 16'h0BAD, 1);
        kick();
        n = 0;
        while (!ld_rdy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("ld_rdy_after_pop", 32'(ld_rdy), 32'd1);
        model_cnt = 0;
        load(24'hB00017, 16'h0017, 16'hFFFF, M_RESP, 16'h0017, $urandom_range(1, 10));
        predict(); wait_run(3000);

        // Abort in the wait of entry 2 of 5.
        for (int i = 0; i < 5; i++)
            load(24'(24'hC00000 + i), 16'(16'h0100 + i), 16'hFFFF,
                 (i == 2) ? M_ABORT : M_RESP, 16'(16'h0100 + i), $urandom_range(1, 10));
        kick();
        n = 0;
        while (busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("abort_to_idle", 32'(n < 500), 32'd1);
        exp_q.delete(); plan_q.delete();
        run_exp.delete(); run_mask.delete(); run_rsp.delete(); run_mode.delete();
        model_cnt = 0;
        repeat (2) @(negedge clk);
        check("abort_pass_held", 32'(pass_cnt), 32'd2);
        check("abort_fail_held", 32'(fail_cnt), 32'd0);
        check("abort_ld_rdy", 32'(ld_rdy), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        predict(); kick(); wait_run(100);

        // rsp_rdy held high across two entries, then a stray pulse in the gap.
        load(24'h0E0042, 16'h0042, 16'hFFFF, M_HOLD, 16'h0042, $urandom_range(1, 10));
        load(24'h0E0043, 16'h0043, 16'hFFFF, M_SSTRAY, 16'h0000, 1);
        predict(); kick(); wait_run(1000);

        // Randomised runs: mixed pass, masked fail and timeout entries.
        for (int run = 0; run < 5; run++) begin
            for (int i = 0; i < $urandom_range(1, 6); i++) begin
                e = 16'($urandom);
                m = 16'($urandom);
                if (m == 16'h0) m = 16'h0001;
                nz = 16'($urandom) & ~m;
                case ($urandom_range(0, 3))
                    0, 1: load(24'($urandom), e, m, M_RESP, (e & m) | nz, $urandom_range(1, 10));
                    2: begin
                        b = $urandom_range(0, 15);
                        while (m[b] == 1'b0) b = (b + 1) % 16;
                        r = (e ^ (16'h1 << b)) & m;
                        load(24'($urandom), e, m, M_RESP, r | nz, $urandom_range(1, 10));
                    end
                    default: load(24'($urandom), e, m, M_SILENT, 16'h0000, 1);
                endcase
            end
            predict(); kick(); wait_run(2000);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size() + res_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
